// File: rtl/block_read_checker_if.sv
// block_read_checker_if: block-read request/burst bus between checker (master) and multiplier (slave)
interface block_read_checker_if #(
    parameter int WIDTH = 32
);
    logic             EN_blockRead;
    logic             VALID_memVal;
    logic [WIDTH-1:0] memVal_data;

    modport master (
        output EN_blockRead,
        input  VALID_memVal,
        input  memVal_data
    );

    modport slave (
        input  EN_blockRead,
        output VALID_memVal,
        output memVal_data
    );
endinterface

// File: rtl/block_read_checker.sv
// block_read_checker: requests a block read, checks each word equals idx*idx, and accumulates checksum/error stats
// Optional capture buffer with cap_addr/cap_data read port: define BLOCK_READ_CHECKER_CAPTURE_EN.
module block_read_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    block_read_checker_if.master  bus,
    output logic                  done,
    output logic [ADDR_W:0]       word_count,
    output logic [ADDR_W:0]       err_count,
    output logic [ADDR_W-1:0]     first_err_idx,
    output logic [WIDTH-1:0]      checksum,
    output logic                  timeout_err,
`ifdef BLOCK_READ_CHECKER_CAPTURE_EN
    input  logic [ADDR_W-1:0]     cap_addr,
    output logic [WIDTH-1:0]      cap_data,
`endif
    output logic                  stray_valid
);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [IDLE_W-1:0] IDLE_ONE = 1;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [ADDR_W:0]     err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_idx_q, first_err_idx_d;
    logic [WIDTH-1:0]    checksum_q, checksum_d;
    logic                timeout_err_q, timeout_err_d;
    logic                stray_valid_q, stray_valid_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [ADDR_W-1:0]   idx;
    logic [2*ADDR_W-1:0] sq;
    logic [WIDTH-1:0]    expected;

    assign idx      = word_count_q[ADDR_W-1:0];
    assign sq       = {{ADDR_W{1'b0}}, idx} * {{ADDR_W{1'b0}}, idx};
    assign expected = WIDTH'(sq);

    // Next-state and result accumulation for the request/collect sequence
    always_comb begin
        state_d         = state_q;
        word_count_d    = word_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        checksum_d      = checksum_q;
        timeout_err_d   = timeout_err_q;
        stray_valid_d   = stray_valid_q | bus.VALID_memVal;
        idle_d          = idle_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d         = S_REQ;
                word_count_d    = '0;
                err_count_d     = '0;
                first_err_idx_d = '0;
                checksum_d      = '0;
                timeout_err_d   = 1'b0;
                stray_valid_d   = 1'b0;
                idle_d          = '0;
            end
            S_REQ: state_d = S_COLLECT;
            S_COLLECT: begin
                stray_valid_d = stray_valid_q;
                if (bus.VALID_memVal) begin
                    checksum_d   = checksum_q + bus.memVal_data;
                    word_count_d = word_count_q + CNT_ONE;
                    idle_d       = '0;
                    if (bus.memVal_data != expected) begin
                        err_count_d = err_count_q + CNT_ONE;
                        if (err_count_q == '0) first_err_idx_d = idx;
                    end
                    if (idx == ADDR_W'(DEPTH - 1)) state_d = S_DONE;
                end else begin
                    idle_d = idle_q + IDLE_ONE;
                    if (idle_d == IDLE_W'(TIMEOUT)) begin
                        state_d       = S_DONE;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            word_count_q    <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            checksum_q      <= '0;
            timeout_err_q   <= 1'b0;
            stray_valid_q   <= 1'b0;
            idle_q          <= '0;
        end else begin
            state_q         <= state_d;
            word_count_q    <= word_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            checksum_q      <= checksum_d;
            timeout_err_q   <= timeout_err_d;
            stray_valid_q   <= stray_valid_d;
            idle_q          <= idle_d;
        end
    end

`ifdef BLOCK_READ_CHECKER_CAPTURE_EN
    logic [WIDTH-1:0] cap_mem_q [DEPTH];

    // Capture each accepted word at its index; contents survive reset and start
    always_ff @(posedge clk) begin
        if (state_q == S_COLLECT && bus.VALID_memVal) cap_mem_q[idx] <= bus.memVal_data;
    end

    assign cap_data = cap_mem_q[cap_addr];
`endif

    assign busy             = state_q != S_IDLE;
    assign done             = state_q == S_DONE;
    assign bus.EN_blockRead = state_q == S_REQ;
    assign word_count       = word_count_q;
    assign err_count        = err_count_q;
    assign first_err_idx    = first_err_idx_q;
    assign checksum         = checksum_q;
    assign timeout_err      = timeout_err_q;
    assign stray_valid      = stray_valid_q;
endmodule

// File: doc/block_read_checker.md
Name: block_read_checker

Overview:
- Receiving end of the multiplier block-read interface.
- On command, issues a one-cycle EN_blockRead request, then consumes the VALID_memVal/memVal_data burst of DEPTH words.
- Checks each word against the expected square of its index, and accumulates a checksum, error count and first-error index for bench and on-chip self-test use.
- Sits beside the multiplier, attached to its block-read port.

Parameters:
- WIDTH, 32, data word width; matches the multiplier memory word.
- DEPTH, 64, words per burst; power of two.
- ADDR_W, 6, index width; equals log2(DEPTH).
- TIMEOUT, 255, maximum consecutive idle cycles tolerated in COLLECT.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a check; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- EN_blockRead  out  1  one-cycle read request to the multiplier.
- VALID_memVal  in  1  burst word valid.
- memVal_data  in  WIDTH  burst word.
- done  out  1  one-cycle pulse at end of check.
- word_count  out  ADDR_W+1  words accepted in the current or last check.
- err_count  out  ADDR_W+1  mismatching words.
- first_err_idx  out  ADDR_W  index of first mismatch; 0 if none.
- checksum  out  WIDTH  sum of accepted words, modulo 2^WIDTH.
- timeout_err  out  1  last check ended by timeout.
- stray_valid  out  1  sticky; VALID_memVal seen outside COLLECT.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; every output and internal counter is 0.
- States:
  - IDLE: start=1 -> REQ. Entering REQ clears word_count, err_count, first_err_idx, checksum, timeout_err, stray_valid and the idle counter.
  - REQ: EN_blockRead=1 for exactly this cycle -> COLLECT unconditionally. EN_blockRead rises the cycle after start is sampled.
  - COLLECT, per cycle with VALID_memVal=1:
    - expected = (idx*idx) truncated to WIDTH, where idx = word_count[ADDR_W-1:0].
    - checksum += memVal_data; word_count++.
    - If the word mismatches: err_count++, and if err_count was 0, first_err_idx=idx.
    - Idle counter resets to 0.
    - If this was word DEPTH-1 -> DONE.
  - COLLECT, per cycle with VALID_memVal=0: idle counter++. When it reaches TIMEOUT -> DONE with timeout_err=1. Words already accepted are kept.
  - DONE: done=1 for this cycle only -> IDLE.
- Latency: done is high on the cycle after the last word is sampled.
- Result outputs are registered. They hold their values from DONE until the next entry to REQ.
- VALID_memVal=1 in IDLE, REQ or DONE: data is ignored and stray_valid is set (sticky).
- start while busy: ignored, no restart.
- start held high: one check runs; a new check begins on the first IDLE cycle in which start is still high.
- Multiply: the index square needs at most 2*ADDR_W bits; zero-extend it to WIDTH, or truncate if WIDTH is smaller.
- Wrap-around: word_count counts up to DEPTH exactly, so it is never ambiguous. The checksum wraps silently.
- Reset mid-burst: returns to IDLE immediately with all outputs 0. Remaining input words are flagged as stray.

Optional Feature:
- Macro: BLOCK_READ_CHECKER_CAPTURE_EN.
- When defined:
  - Adds a DEPTH x WIDTH capture buffer, written at idx for each accepted word in COLLECT.
  - Adds ports cap_addr (in, ADDR_W) and cap_data (out, WIDTH) as a combinational read of the buffer.
  - Buffer contents are not cleared by reset or by start.
- When undefined: no buffer and no cap_* ports. All other behaviour is identical.

Test Plan:
- Normal burst: pulse start; feed 64 back-to-back words i*i, i=0..63 -> EN_blockRead high exactly 1 cycle after start; done 1 cycle after word 63; word_count=64, err_count=0, checksum=85344, timeout_err=0.
- Single error: word 5 = 26 instead of 25 -> err_count=1, first_err_idx=5, checksum=85345.
- Gapped burst: random 0-10 cycle gaps between words, all gaps < TIMEOUT -> same results as the normal burst; done on the cycle after word 63.
- Stall: stop after 10 good words and hold valid low for 255 cycles -> done; timeout_err=1, word_count=10, err_count=0, checksum=285.
- Control hazards:
  - start re-pulsed during COLLECT -> no second EN_blockRead.
  - valid asserted in IDLE -> stray_valid=1, counters unchanged.
  - Next start -> stray_valid cleared.
- Reset mid-burst: assert rst low after word 30 -> all outputs 0 asynchronously, busy=0. A new start then runs a clean 64-word check.
